// File: rtl/mem_access_unit_if.sv
// Load/store op, completion and cache request/response signals of the memory access unit.
// The unit sits on the slave side; the pipeline/cache environment drives the master side.
interface mem_access_unit_if;
  logic        op_valid;
  logic        op_ready;
  logic        op_load;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        done_valid;
  logic [31:0] done_data;
  logic [1:0]  done_fault;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;

  modport master (
    output op_valid, op_load, op_store, op_funct3, op_addr, op_wdata,
    input  op_ready, done_valid, done_data, done_fault,
    input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    output response_enable, resp_data
  );

  modport slave (
    input  op_valid, op_load, op_store, op_funct3, op_addr, op_wdata,
    output op_ready, done_valid, done_data, done_fault,
    output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    input  response_enable, resp_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage ahead of the cache: byte strobes, lane-shifted store data, misaligned splitting
// into two word accesses, and load merge/align/extend. One op in flight.
module mem_access_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT0, WAIT1, DONE} state_t;

  state_t      state;
  logic        is_load_p0;
  logic [2:0]  f3_p0;
  logic [1:0]  off_p0;
  logic        split_p0;
  logic [31:0] hi_wdata_p0;
  logic [3:0]  hi_wstrb_p0;
  logic [31:0] lo_data_p1;

  logic [1:0]  off;
  logic        legal_f3;
  logic        illegal;
  logic        misal;
  logic [3:0]  base_mask;
  logic [7:0]  mask8;
  logic [31:0] wmask;
  logic [63:0] wdata64;
  logic [55:0] ld_merge;
  logic [31:0] ld_result;

  function automatic logic [31:0] align_load(input logic [55:0] d, input logic [1:0] sh);
    case (sh)
      2'd0:    align_load = d[31:0];
      2'd1:    align_load = d[39:8];
      2'd2:    align_load = d[47:16];
      default: align_load = d[55:24];
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] v, input logic [2:0] f3);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] r;
    sb = v[7:0];
    sh = v[15:0];
    case (f3)
      3'b000:  r = 32'(sb);
      3'b001:  r = 32'(sh);
      3'b100:  r = {24'h0, v[7:0]};
      3'b101:  r = {16'h0, v[15:0]};
      default: r = v;
    endcase
    extend_load = r;
  endfunction

  // accept-time decode: legality, alignment, strobes over the two-word window
  always_comb begin
    off = bus.op_addr[1:0];
    if (bus.op_load)
      legal_f3 = bus.op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      legal_f3 = bus.op_funct3 inside {3'b000, 3'b001, 3'b010};
    illegal = (bus.op_load == bus.op_store) || !legal_f3;
    case (bus.op_funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    misal = ((bus.op_funct3[1:0] == 2'b01) && off[0]) ||
            ((bus.op_funct3[1:0] == 2'b10) && (off != 2'b00));
    mask8   = {4'b0000, base_mask} << off;
    wmask   = {{8{base_mask[3]}}, {8{base_mask[2]}}, {8{base_mask[1]}}, {8{base_mask[0]}}};
    wdata64 = {32'h0, bus.op_wdata & wmask} << {off, 3'b000};
  end

  // response stage: {second, first} window, shifted down to the access offset
  always_comb begin
    ld_merge  = split_p0 ? {bus.resp_data[23:0], lo_data_p1} : {24'h0, bus.resp_data};
    ld_result = extend_load(align_load(ld_merge, off_p0), f3_p0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      bus.op_ready       <= 1'b1;
      bus.done_valid     <= 1'b0;
      bus.done_data      <= '0;
      bus.done_fault     <= 2'b00;
      bus.request_enable <= 1'b0;
      bus.req_mode       <= 1'b0;
      bus.req_addr       <= '0;
      bus.req_wdata      <= '0;
      bus.req_wstrb      <= '0;
      is_load_p0         <= 1'b0;
      f3_p0              <= '0;
      off_p0             <= '0;
      split_p0           <= 1'b0;
      hi_wdata_p0        <= '0;
      hi_wstrb_p0        <= '0;
      lo_data_p1         <= '0;
    end else begin
      bus.request_enable <= 1'b0;
      bus.done_valid     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            bus.op_ready <= 1'b0;
            is_load_p0   <= bus.op_load;
            f3_p0        <= bus.op_funct3;
            off_p0       <= off;
            split_p0     <= (mask8[7:4] != 4'b0000);
            hi_wdata_p0  <= bus.op_store ? wdata64[63:32] : 32'h0;
            hi_wstrb_p0  <= bus.op_store ? mask8[7:4] : 4'b0000;
            if (illegal) begin
              bus.done_valid <= 1'b1;
              bus.done_fault <= 2'b11;
              bus.done_data  <= '0;
              state          <= DONE;
            end else if (misal && !SPLIT_MISALIGNED) begin
              bus.done_valid <= 1'b1;
              bus.done_fault <= bus.op_load ? 2'b01 : 2'b10;
              bus.done_data  <= '0;
              state          <= DONE;
            end else begin
              bus.request_enable <= 1'b1;
              bus.req_mode       <= bus.op_store;
              bus.req_addr       <= {bus.op_addr[31:2], 2'b00};
              bus.req_wstrb      <= bus.op_store ? mask8[3:0] : 4'b0000;
              bus.req_wdata      <= bus.op_store ? wdata64[31:0] : 32'h0;
              state              <= WAIT0;
            end
          end
        end
        WAIT0: begin
          if (bus.response_enable) begin
            if (split_p0) begin
              lo_data_p1         <= bus.resp_data;
              bus.request_enable <= 1'b1;
              bus.req_addr       <= bus.req_addr + 32'd4;
              bus.req_wstrb      <= hi_wstrb_p0;
              bus.req_wdata      <= hi_wdata_p0;
              state              <= WAIT1;
            end else begin
              bus.done_valid <= 1'b1;
              bus.done_fault <= 2'b00;
              bus.done_data  <= is_load_p0 ? ld_result : 32'h0;
              state          <= DONE;
            end
          end
        end
        WAIT1: begin
          if (bus.response_enable) begin
            bus.done_valid <= 1'b1;
            bus.done_fault <= 2'b00;
            bus.done_data  <= is_load_p0 ? ld_result : 32'h0;
            state          <= DONE;
          end
        end
        DONE: begin
          bus.op_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-addressed memory reference model.
module tb_mem_access_unit;

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } req_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_access_unit_if b0 ();
  mem_access_unit_if b1 ();

  mem_access_unit #(.SPLIT_MISALIGNED(1'b1)) dut    (.clk(clk), .rst(rst), .bus(b0.slave));
  mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) dut_ns (.clk(clk), .rst(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  rmem [bit [31:0]];
  logic [31:0] cmem [bit [31:0]];
  int          rs0 [$];
  req_t        rq [$];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] cache_rd(input logic [31:0] w);
    if (cmem.exists(w)) return cmem[w];
    return {init_byte(w + 32'd3), init_byte(w + 32'd2), init_byte(w + 32'd1), init_byte(w)};
  endfunction

  task automatic preload(input logic [31:0] w, input logic [31:0] val);
    cmem[w] = val;
    for (int i = 0; i < 4; i++) rmem[w + i] = val[8*i +: 8];
  endtask

  // cache model: responds 1..3 cycles after each request, applies write strobes
  initial begin : cache_model
    logic [31:0] wa, w;
    int lat;
    b0.response_enable = 1'b0;
    b0.resp_data       = '0;
    forever begin
      @(posedge clk); #1;
      b0.response_enable = 1'b0;
      if (b0.request_enable === 1'b1 && rst === 1'b0) begin
        wa = b0.req_addr;
        if (b0.req_mode) begin
          w = cache_rd(wa);
          for (int i = 0; i < 4; i++) if (b0.req_wstrb[i]) w[8*i +: 8] = b0.req_wdata[8*i +: 8];
          cmem[wa] = w;
        end
        lat = $urandom_range(1, 3);
        repeat (lat) begin @(posedge clk); #1; end
        b0.resp_data       = b0.req_mode ? $urandom : cache_rd(wa);
        b0.response_enable = 1'b1;
        rs0.push_back(cyc);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold,
                        output logic [31:0] got_d, output logic [1:0] got_f);
    int n, nw, t0, tdone, rbase, tmo;
    logic [31:0] ew_addr [2];
    logic [31:0] ew_data [2];
    logic [3:0]  ew_strb [2];
    logic [31:0] ba, v, exp_d;
    logic [1:0]  exp_f;
    bit ill, seen;
    n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ill = (ld == st) || (ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(f3 inside {3'd0, 3'd1, 3'd2}));
    exp_f = ill ? 2'b11 : 2'b00;
    nw = 0; v = '0;
    if (!ill) begin
      for (int i = 0; i < n; i++) begin
        ba = addr + i;
        if (nw == 0 || ew_addr[nw-1] != {ba[31:2], 2'b00}) begin
          ew_addr[nw] = {ba[31:2], 2'b00}; ew_data[nw] = '0; ew_strb[nw] = '0; nw++;
        end
        if (st) begin
          ew_strb[nw-1][ba[1:0]] = 1'b1;
          ew_data[nw-1][8*ba[1:0] +: 8] = wd[8*i +: 8];
        end
        v[8*i +: 8] = rd_byte(ba);
      end
    end
    if (!ld || ill) exp_d = '0;
    else case (n)
      1:       exp_d = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2:       exp_d = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: exp_d = v;
    endcase

    tmo = 0;
    @(posedge clk); #1;
    while (b0.op_ready !== 1'b1 && tmo < 20) begin @(posedge clk); #1; tmo++; end
    n_chk++;
    if (b0.op_ready !== 1'b1) begin n_fail++; $display("FAIL op_ready_wait: got %b, expected 1", b0.op_ready); end
    b0.op_valid = 1'b1; b0.op_load = ld; b0.op_store = st; b0.op_funct3 = f3;
    b0.op_addr = addr; b0.op_wdata = wd;
    t0 = cyc; rbase = rs0.size(); rq.delete(); seen = 0; tdone = 0;
    got_d = 'x; got_f = 'x;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (cyc > t0) begin
        if (hold) begin
          b0.op_load = 1'b0; b0.op_store = 1'b1; b0.op_funct3 = 3'b010;
          b0.op_addr = 32'h0000_0500; b0.op_wdata = 32'h5A5A5A5A;
        end else b0.op_valid = 1'b0;
      end
      if (b0.request_enable === 1'b1) begin
        rq.push_back('{b0.req_mode, b0.req_addr, b0.req_wdata, b0.req_wstrb, cyc});
        n_chk++;
        if (b0.response_enable !== 1'b0) begin
          n_fail++; $display("FAIL req_resp_overlap: response_enable=%b with request_enable=1, expected 0", b0.response_enable);
        end
      end
      if (b0.done_valid === 1'b1) begin
        seen = 1; tdone = cyc; got_d = b0.done_data; got_f = b0.done_fault;
        n_chk++;
        if (b0.op_ready !== 1'b0) begin n_fail++; $display("FAIL ready_while_done: got %b, expected 0", b0.op_ready); end
      end
    end
    b0.op_valid = 1'b0;
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL done_timeout: got no done_valid, expected one (addr %h)", addr); end
    n_chk++;
    if (got_f !== exp_f) begin n_fail++; $display("FAIL done_fault: got %b, expected %b (addr %h f3 %b)", got_f, exp_f, addr, f3); end
    n_chk++;
    if (got_d !== exp_d) begin n_fail++; $display("FAIL done_data: got %h, expected %h (addr %h f3 %b)", got_d, exp_d, addr, f3); end
    n_chk++;
    if (ill) begin
      if (tdone !== t0 + 1) begin n_fail++; $display("FAIL fault_latency: got cycle %0d, expected %0d", tdone, t0 + 1); end
    end else if (rs0.size() <= rbase || tdone !== rs0[rs0.size()-1] + 1) begin
      n_fail++; $display("FAIL done_latency: done at cycle %0d, expected one cycle after last response", tdone);
    end
    n_chk++;
    if (rq.size() !== nw) begin n_fail++; $display("FAIL req_count: got %0d, expected %0d (addr %h)", rq.size(), nw, addr); end
    for (int k = 0; k < nw && k < rq.size(); k++) begin
      n_chk++;
      if (rq[k].addr !== ew_addr[k] || rq[k].mode !== st || rq[k].wstrb !== ew_strb[k] || rq[k].wdata !== ew_data[k]) begin
        n_fail++;
        $display("FAIL req%0d: got addr %h mode %b strb %b data %h, expected addr %h mode %b strb %b data %h",
                 k, rq[k].addr, rq[k].mode, rq[k].wstrb, rq[k].wdata, ew_addr[k], st, ew_strb[k], ew_data[k]);
      end
    end
    if (nw >= 1 && rq.size() >= 1) begin
      n_chk++;
      if (rq[0].cyc !== t0 + 1) begin n_fail++; $display("FAIL req0_timing: got cycle %0d, expected %0d", rq[0].cyc, t0 + 1); end
    end
    if (nw == 2 && rq.size() == 2 && rs0.size() > rbase) begin
      n_chk++;
      if (rq[1].cyc !== rs0[rbase] + 1) begin
        n_fail++; $display("FAIL req1_timing: got cycle %0d, expected %0d", rq[1].cyc, rs0[rbase] + 1);
      end
    end
    @(negedge clk);
    n_chk++;
    if (b0.op_ready !== 1'b1 || b0.done_valid !== 1'b0) begin
      n_fail++; $display("FAIL ready_after_done: got ready %b done %b, expected 1 0", b0.op_ready, b0.done_valid);
    end
    if (st && !ill) for (int i = 0; i < n; i++) rmem[addr + i] = wd[8*i +: 8];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({b0.op_ready, b0.done_valid, b0.done_fault, b0.request_enable, b0.req_mode, b0.req_wstrb} !== 10'b10_0000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready %b done %b fault %b req %b mode %b strb %b, expected 1 0 00 0 0 0000",
               b0.op_ready, b0.done_valid, b0.done_fault, b0.request_enable, b0.req_mode, b0.req_wstrb);
    end
    n_chk++;
    if ({b0.done_data, b0.req_addr, b0.req_wdata} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got data %h addr %h wdata %h, expected all 0", b0.done_data, b0.req_addr, b0.req_wdata);
    end
    n_chk++;
    if (b1.op_ready !== 1'b1 || b1.done_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ns: got ready %b done %b, expected 1 0", b1.op_ready, b1.done_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] d;
    logic [1:0]  f;
    preload(32'h100, 32'hDEADBEEF);
    run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, d, f);
    n_chk++;
    if (d !== 32'hDEADBEEF || f !== 2'b00 || rq.size() != 1) begin
      n_fail++; $display("FAIL lw_aligned: got %h fault %b reqs %0d, expected deadbeef 00 1", d, f, rq.size());
    end else begin
      n_chk++;
      if (rq[0].addr !== 32'h100 || rq[0].wstrb !== 4'b0000 || rq[0].mode !== 1'b0) begin
        n_fail++; $display("FAIL lw_req: got addr %h strb %b mode %b, expected 100 0000 0", rq[0].addr, rq[0].wstrb, rq[0].mode);
      end
    end
    preload(32'h100, 32'h80123456);
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 0, d, f);
    n_chk++;
    if (d !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sign: got %h, expected ffffff80", d); end
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 0, d, f);
    n_chk++;
    if (d !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zero: got %h, expected 00000080", d); end
    run_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, d, f);
    n_chk++;
    if (rq.size() != 1 || rq[0].addr !== 32'h100 || rq[0].wstrb !== 4'b1100 || rq[0].wdata !== 32'hABCD0000 || rq[0].mode !== 1'b1) begin
      n_fail++; $display("FAIL sh_lanes: got %0d reqs, expected one req addr 100 strb 1100 wdata abcd0000 mode 1", rq.size());
    end
    preload(32'h100, 32'h44332211);
    preload(32'h104, 32'h88776655);
    run_op(1, 0, 3'b010, 32'h101, 32'h0, 0, d, f);
    n_chk++;
    if (d !== 32'h55443322 || rq.size() != 2) begin
      n_fail++; $display("FAIL lw_split: got %h with %0d reqs, expected 55443322 with 2", d, rq.size());
    end else begin
      n_chk++;
      if (rq[0].addr !== 32'h100 || rq[1].addr !== 32'h104) begin
        n_fail++; $display("FAIL lw_split_addr: got %h %h, expected 100 104", rq[0].addr, rq[1].addr);
      end
    end
    run_op(0, 1, 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD, 0, d, f);
    n_chk++;
    if (rq.size() != 2) begin
      n_fail++; $display("FAIL sw_wrap_count: got %0d reqs, expected 2", rq.size());
    end else begin
      n_chk++;
      if (rq[0].addr !== 32'hFFFFFFFC || rq[0].wstrb !== 4'b1100 || rq[0].wdata !== 32'hCCDD0000 ||
          rq[1].addr !== 32'h0 || rq[1].wstrb !== 4'b0011 || rq[1].wdata !== 32'h0000AABB) begin
        n_fail++;
        $display("FAIL sw_wrap: got %h/%b/%h then %h/%b/%h, expected fffffffc/1100/ccdd0000 then 0/0011/0000aabb",
                 rq[0].addr, rq[0].wstrb, rq[0].wdata, rq[1].addr, rq[1].wstrb, rq[1].wdata);
      end
    end
    run_op(1, 1, 3'b010, 32'h200, 32'h0, 0, d, f);
    n_chk++;
    if (f !== 2'b11) begin n_fail++; $display("FAIL illegal_both: got %b, expected 11", f); end
    run_op(0, 1, 3'b100, 32'h200, 32'h0, 0, d, f);
    n_chk++;
    if (f !== 2'b11) begin n_fail++; $display("FAIL illegal_sbu: got %b, expected 11", f); end
  endtask

  task automatic ns_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr, input logic [1:0] exp_f);
    @(posedge clk); #1;
    b1.op_valid = 1'b1; b1.op_load = ld; b1.op_store = st; b1.op_funct3 = f3;
    b1.op_addr = addr; b1.op_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    b1.op_valid = 1'b0;
    n_chk++;
    if (b1.done_valid !== 1'b1 || b1.done_fault !== exp_f || b1.done_data !== 32'h0 ||
        b1.request_enable !== 1'b0 || b1.op_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nosplit_fault: got done %b fault %b data %h req %b ready %b, expected 1 %b 0 0 0",
               b1.done_valid, b1.done_fault, b1.done_data, b1.request_enable, b1.op_ready, exp_f);
    end
    @(posedge clk); #1;
    n_chk++;
    if (b1.op_ready !== 1'b1 || b1.done_valid !== 1'b0 || b1.request_enable !== 1'b0) begin
      n_fail++; $display("FAIL nosplit_recover: got ready %b done %b req %b, expected 1 0 0", b1.op_ready, b1.done_valid, b1.request_enable);
    end
  endtask

  task automatic test_nosplit;
    ns_op(1, 0, 3'b001, 32'h101, 2'b01);
    ns_op(1, 0, 3'b010, 32'h102, 2'b01);
    ns_op(0, 1, 3'b010, 32'h103, 2'b10);
    ns_op(0, 1, 3'b001, 32'h105, 2'b10);
    ns_op(1, 1, 3'b000, 32'h100, 2'b11);
  endtask

  task automatic test_reset_midop;
    int bad_done, bad_req;
    @(posedge clk); #1;
    b0.op_valid = 1'b1; b0.op_load = 1'b1; b0.op_store = 1'b0; b0.op_funct3 = 3'b010;
    b0.op_addr = 32'h300; b0.op_wdata = 32'h0;
    @(posedge clk); #1;
    b0.op_valid = 1'b0;
    n_chk++;
    if (b0.request_enable !== 1'b1) begin n_fail++; $display("FAIL midop_req: got %b, expected 1", b0.request_enable); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad_done = 0; bad_req = 0;
    repeat (10) begin
      @(negedge clk);
      if (b0.done_valid !== 1'b0) bad_done++;
      if (b0.request_enable !== 1'b0) bad_req++;
    end
    n_chk++;
    if (bad_done != 0 || bad_req != 0) begin
      n_fail++; $display("FAIL midop_reset: got %0d done and %0d req cycles, expected 0 0", bad_done, bad_req);
    end
    n_chk++;
    if (b0.op_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready: got %b, expected 1", b0.op_ready); end
  endtask

  function automatic logic [2:0] pick_f3();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0, 1:    return 3'b000;
      2, 3:    return 3'b001;
      4, 5, 6: return 3'b010;
      7:       return 3'b100;
      8:       return 3'b101;
      default: return 3'($urandom);
    endcase
  endfunction

  task automatic random_ops(input int count, input bit hold);
    logic [31:0] d, addr;
    logic [1:0]  f;
    bit ld, st;
    int r;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0)      begin ld = 1; st = 1; end
      else if (r == 1) begin ld = 0; st = 0; end
      else             begin ld = r[0]; st = !r[0]; end
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                         : (32'h0000_0400 + ($urandom & 32'h7F));
      run_op(ld, st, pick_f3(), addr, $urandom, hold, d, f);
    end
  endtask

  task automatic test_random;
    random_ops(80, 1'b0);
  endtask

  task automatic test_back_to_back;
    random_ops(12, 1'b1);
  endtask

  initial begin : main
    rst = 1'b1;
    b0.op_valid = 1'b0; b0.op_load = 1'b0; b0.op_store = 1'b0; b0.op_funct3 = '0;
    b0.op_addr = '0; b0.op_wdata = '0;
    b1.op_valid = 1'b0; b1.op_load = 1'b0; b1.op_store = 1'b0; b1.op_funct3 = '0;
    b1.op_addr = '0; b1.op_wdata = '0;
    b1.response_enable = 1'b0; b1.resp_data = '0;
    test_reset;
    test_directed;
    test_nosplit;
    test_reset_midop;
    test_random;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
